alu_issue_station: RTL and testbench

Reservation station and issue scheduler for the combinational ALU. It accepts decoded integer, branch and jump instructions from dispatch, holds them until both source operands are available, and snoops two CDB ports for operand wake-up. Each cycle it selects one ready entry and drives the ALU input bundle from registers. It sits between the dispatcher/ROB and the ALU, and owns the ALU's only request path.

---
 rtl/alu_issue_station_pkg.sv | 19 +
 rtl/alu_issue_station_if.sv | 49 ++++
 rtl/alu_issue_station_rs_pick.sv | 23 ++
 rtl/alu_issue_station.sv | 174 +++++++++++++++++
 tb/tb_alu_issue_station.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_station_pkg.sv
// Shared definitions for the ALU issue station: ROB tag width, default
// station depth and the internal opcode encoding used by dispatch and the ALU.
package alu_issue_station_pkg;

   localparam int ROBENTRY    = 4;
   localparam int RS_SIZE_DEF = 8;

   typedef enum logic [5:0] {
      OP_ADD  = 6'd0,
      OP_SUB  = 6'd1,
      OP_AND  = 6'd2,
      OP_OR   = 6'd3,
      OP_XOR  = 6'd4,
      OP_ADDI = 6'd5,
      OP_BEQ  = 6'd6,
      OP_JAL  = 6'd7
   } opcode_e;

endpackage

// File: rtl/alu_issue_station_if.sv
// Bundle of dispatch, CDB snoop and ALU issue signals around the issue station.
// The station uses the slave view; the surrounding pipeline uses the master view.
interface alu_issue_station_if
   import alu_issue_station_pkg::*;
   #(parameter int ROB_W = ROBENTRY);

   logic             dsp_valid;
   logic [5:0]       dsp_opcode;
   logic [31:0]      dsp_vj;
   logic [31:0]      dsp_vk;
   logic             dsp_qj_busy;
   logic             dsp_qk_busy;
   logic [ROB_W-1:0] dsp_qj;
   logic [ROB_W-1:0] dsp_qk;
   logic [31:0]      dsp_imm;
   logic [31:0]      dsp_pc;
   logic [ROB_W-1:0] dsp_rob;
   logic             rs_full;

   logic             cdb0_valid;
   logic [ROB_W-1:0] cdb0_rob;
   logic [31:0]      cdb0_value;
   logic             cdb1_valid;
   logic [ROB_W-1:0] cdb1_rob;
   logic [31:0]      cdb1_value;

   logic             RS_sgn;
   logic [5:0]       RS_opcode;
   logic [31:0]      lhs;
   logic [31:0]      rhs;
   logic [31:0]      imm;
   logic [31:0]      pc;
   logic [ROB_W-1:0] ROB_entry;

   modport slave (
      input  dsp_valid, dsp_opcode, dsp_vj, dsp_vk, dsp_qj_busy, dsp_qk_busy,
             dsp_qj, dsp_qk, dsp_imm, dsp_pc, dsp_rob,
             cdb0_valid, cdb0_rob, cdb0_value, cdb1_valid, cdb1_rob, cdb1_value,
      output rs_full, RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry
   );

   modport master (
      output dsp_valid, dsp_opcode, dsp_vj, dsp_vk, dsp_qj_busy, dsp_qk_busy,
             dsp_qj, dsp_qk, dsp_imm, dsp_pc, dsp_rob,
             cdb0_valid, cdb0_rob, cdb0_value, cdb1_valid, cdb1_rob, cdb1_value,
      input  rs_full, RS_sgn, RS_opcode, lhs, rhs, imm, pc, ROB_entry
   );

endinterface

// File: rtl/alu_issue_station_rs_pick.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one. Used for both free-slot and ready-entry search.
module rs_pick
   import alu_issue_station_pkg::*;
   #(parameter int N     = RS_SIZE_DEF,
     parameter int IDX_W = $clog2(N))
   (input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_issue_station.sv
// Reservation station for the ALU: holds dispatched ops until both operands
// are known, snoops two CDB ports for wake-up and issues one ready op per cycle.
module alu_issue_station
   import alu_issue_station_pkg::*;
   #(parameter int RS_SIZE = RS_SIZE_DEF,
     parameter int ROB_W   = ROBENTRY)
   (input  logic clk,
    input  logic rst_n,
    input  logic rdy,
    input  logic clear,
    alu_issue_station_if.slave bus);

   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0] busy;
   logic [RS_SIZE-1:0] qj_busy;
   logic [RS_SIZE-1:0] qk_busy;
   logic [5:0]         opcode_q [RS_SIZE];
   logic [31:0]        vj_q     [RS_SIZE];
   logic [31:0]        vk_q     [RS_SIZE];
   logic [31:0]        imm_q    [RS_SIZE];
   logic [31:0]        pc_q     [RS_SIZE];
   logic [ROB_W-1:0]   qj_q     [RS_SIZE];
   logic [ROB_W-1:0]   qk_q     [RS_SIZE];
   logic [ROB_W-1:0]   rob_q    [RS_SIZE];

   logic [RS_SIZE-1:0] free_vec;
   logic [RS_SIZE-1:0] ready_vec;
   logic               alloc_valid;
   logic               sel_valid;
   logic [IDX_W-1:0]   alloc_idx;
   logic [IDX_W-1:0]   sel_idx;

   logic               dsp_j_pend;
   logic               dsp_k_pend;
   logic [31:0]        dsp_j_val;
   logic [31:0]        dsp_k_val;

   logic               sgn_q;
   logic [5:0]         out_opcode;
   logic [31:0]        out_lhs;
   logic [31:0]        out_rhs;
   logic [31:0]        out_imm;
   logic [31:0]        out_pc;
   logic [ROB_W-1:0]   out_rob;

   assign free_vec    = ~busy;
   assign ready_vec   = busy & ~qj_busy & ~qk_busy;
   assign bus.rs_full = &busy;

   assign bus.RS_sgn    = sgn_q;
   assign bus.RS_opcode = out_opcode;
   assign bus.lhs       = out_lhs;
   assign bus.rhs       = out_rhs;
   assign bus.imm       = out_imm;
   assign bus.pc        = out_pc;
   assign bus.ROB_entry = out_rob;

   rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
      .req   (free_vec),
      .valid (alloc_valid),
      .idx   (alloc_idx)
   );

   rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_pick (
      .req   (ready_vec),
      .valid (sel_valid),
      .idx   (sel_idx)
   );

   // Resolve incoming operands against the CDBs so a producer broadcasting in the dispatch cycle is not missed; cdb0 wins ties.
   always_comb begin
      dsp_j_pend = bus.dsp_qj_busy;
      dsp_j_val  = bus.dsp_vj;
      dsp_k_pend = bus.dsp_qk_busy;
      dsp_k_val  = bus.dsp_vk;
      if (bus.dsp_qj_busy) begin
         if (bus.cdb0_valid && bus.cdb0_rob == bus.dsp_qj) begin
            dsp_j_pend = 1'b0;
            dsp_j_val  = bus.cdb0_value;
         end else if (bus.cdb1_valid && bus.cdb1_rob == bus.dsp_qj) begin
            dsp_j_pend = 1'b0;
            dsp_j_val  = bus.cdb1_value;
         end
      end
      if (bus.dsp_qk_busy) begin
         if (bus.cdb0_valid && bus.cdb0_rob == bus.dsp_qk) begin
            dsp_k_pend = 1'b0;
            dsp_k_val  = bus.cdb0_value;
         end else if (bus.cdb1_valid && bus.cdb1_rob == bus.dsp_qk) begin
            dsp_k_pend = 1'b0;
            dsp_k_val  = bus.cdb1_value;
         end
      end
   end

   // Entry array and issue registers: clear beats everything, then wake-up, issue and allocation all act on pre-edge state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= '0;
         qj_busy    <= '0;
         qk_busy    <= '0;
         sgn_q      <= 1'b0;
         out_opcode <= '0;
         out_lhs    <= '0;
         out_rhs    <= '0;
         out_imm    <= '0;
         out_pc     <= '0;
         out_rob    <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            opcode_q[i] <= '0;
            vj_q[i]     <= '0;
            vk_q[i]     <= '0;
            imm_q[i]    <= '0;
            pc_q[i]     <= '0;
            qj_q[i]     <= '0;
            qk_q[i]     <= '0;
            rob_q[i]    <= '0;
         end
      end else if (rdy) begin
         if (clear) begin
            busy  <= '0;
            sgn_q <= 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy[i] && qj_busy[i]) begin
                  if (bus.cdb0_valid && bus.cdb0_rob == qj_q[i]) begin
                     vj_q[i]    <= bus.cdb0_value;
                     qj_busy[i] <= 1'b0;
                  end else if (bus.cdb1_valid && bus.cdb1_rob == qj_q[i]) begin
                     vj_q[i]    <= bus.cdb1_value;
                     qj_busy[i] <= 1'b0;
                  end
               end
               if (busy[i] && qk_busy[i]) begin
                  if (bus.cdb0_valid && bus.cdb0_rob == qk_q[i]) begin
                     vk_q[i]    <= bus.cdb0_value;
                     qk_busy[i] <= 1'b0;
                  end else if (bus.cdb1_valid && bus.cdb1_rob == qk_q[i]) begin
                     vk_q[i]    <= bus.cdb1_value;
                     qk_busy[i] <= 1'b0;
                  end
               end
            end

            sgn_q <= sel_valid;
            if (sel_valid) begin
               out_opcode    <= opcode_q[sel_idx];
               out_lhs       <= vj_q[sel_idx];
               out_rhs       <= vk_q[sel_idx];
               out_imm       <= imm_q[sel_idx];
               out_pc        <= pc_q[sel_idx];
               out_rob       <= rob_q[sel_idx];
               busy[sel_idx] <= 1'b0;
            end

            if (bus.dsp_valid && alloc_valid) begin
               busy[alloc_idx]     <= 1'b1;
               opcode_q[alloc_idx] <= bus.dsp_opcode;
               vj_q[alloc_idx]     <= dsp_j_val;
               vk_q[alloc_idx]     <= dsp_k_val;
               qj_busy[alloc_idx]  <= dsp_j_pend;
               qk_busy[alloc_idx]  <= dsp_k_pend;
               qj_q[alloc_idx]     <= bus.dsp_qj;
               qk_q[alloc_idx]     <= bus.dsp_qk;
               imm_q[alloc_idx]    <= bus.dsp_imm;
               pc_q[alloc_idx]     <= bus.dsp_pc;
               rob_q[alloc_idx]    <= bus.dsp_rob;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_station.sv
// Directed bench for the ALU issue station: a scoreboard of expected issues
// (with the cycle they must appear in) is checked whenever RS_sgn is high.
module tb_alu_issue_station;
   import alu_issue_station_pkg::*;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] lhs;
      logic [31:0] rhs;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [3:0]  rob;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   logic rdy;
   logic clear;
   int   cyc;
   int   tests;
   int   fails;
   exp_t sb[$];

   alu_issue_station_if #(.ROB_W(ROBENTRY)) bus ();

   alu_issue_station #(.RS_SIZE(8), .ROB_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rdy   (rdy),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so expected issue cycles can be stated absolutely.
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] vj,
                                input logic [31:0] vk, input logic qjb,
                                input logic qkb, input logic [3:0] qj,
                                input logic [3:0] qk, input logic [31:0] im,
                                input logic [31:0] p, input logic [3:0] rob);
      bus.dsp_valid   = 1'b1;
      bus.dsp_opcode  = op;
      bus.dsp_vj      = vj;
      bus.dsp_vk      = vk;
      bus.dsp_qj_busy = qjb;
      bus.dsp_qk_busy = qkb;
      bus.dsp_qj      = qj;
      bus.dsp_qk      = qk;
      bus.dsp_imm     = im;
      bus.dsp_pc      = p;
      bus.dsp_rob     = rob;
   endtask

   task automatic idle();
      bus.dsp_valid  = 1'b0;
      bus.cdb0_valid = 1'b0;
      bus.cdb1_valid = 1'b0;
   endtask

   task automatic expectIssue(input logic [5:0] op, input logic [31:0] l,
                              input logic [31:0] r, input logic [31:0] im,
                              input logic [31:0] p, input logic [3:0] rob,
                              input int at);
      exp_t e;
      e.op = op; e.lhs = l; e.rhs = r; e.imm = im; e.pc = p; e.rob = rob; e.cyc = at;
      sb.push_back(e);
   endtask

   // Every issue must match the oldest scoreboard entry, including its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.RS_sgn === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("issue_without_expectation", {31'b0, bus.RS_sgn}, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("issue_cycle", cyc, e.cyc);
            checkOutput("issue_opcode", {26'b0, bus.RS_opcode}, {26'b0, e.op});
            checkOutput("issue_lhs", bus.lhs, e.lhs);
            checkOutput("issue_rhs", bus.rhs, e.rhs);
            checkOutput("issue_imm", bus.imm, e.imm);
            checkOutput("issue_pc", bus.pc, e.pc);
            checkOutput("issue_rob", {28'b0, bus.ROB_entry}, {28'b0, e.rob});
         end
      end
   end

   initial begin
      cyc = 0; tests = 0; fails = 0;
      rst_n = 1'b0; rdy = 1'b1; clear = 1'b0;
      bus.dsp_opcode = '0; bus.dsp_vj = '0; bus.dsp_vk = '0;
      bus.dsp_qj_busy = 1'b0; bus.dsp_qk_busy = 1'b0; bus.dsp_qj = '0; bus.dsp_qk = '0;
      bus.dsp_imm = '0; bus.dsp_pc = '0; bus.dsp_rob = '0;
      bus.cdb0_rob = '0; bus.cdb0_value = '0; bus.cdb1_rob = '0; bus.cdb1_value = '0;
      idle();
      tick(); tick();
      checkOutput("reset_sgn", {31'b0, bus.RS_sgn}, 32'd0);
      checkOutput("reset_lhs", bus.lhs, 32'd0);
      checkOutput("reset_rs_full", {31'b0, bus.rs_full}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Ready ADD: issues two edges after dispatch, for one cycle only.
      applyStimulus(OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h100, 4'd1);
      expectIssue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h100, 4'd1, cyc + 2);
      tick(); idle();
      tick(); tick();
      checkOutput("ready_one_cycle_only", {31'b0, bus.RS_sgn}, 32'd0);

      // Dependent ADDI waits for rob 3 on cdb0.
      applyStimulus(OP_ADDI, 32'd0, 32'd0, 1'b1, 1'b0, 4'd3, 4'd0, 32'd4, 32'h200, 4'd2);
      tick(); idle();
      tick(); tick();
      checkOutput("dep_no_early_issue", {31'b0, bus.RS_sgn}, 32'd0);
      bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'd3; bus.cdb0_value = 32'h10;
      expectIssue(OP_ADDI, 32'h10, 32'd0, 32'd4, 32'h200, 4'd2, cyc + 2);
      tick(); idle();
      tick(); tick();

      // Dispatch bypass from cdb1.
      applyStimulus(OP_SUB, 32'd9, 32'd0, 1'b0, 1'b1, 4'd0, 4'd2, 32'd0, 32'h300, 4'd3);
      bus.cdb1_valid = 1'b1; bus.cdb1_rob = 4'd2; bus.cdb1_value = 32'hAB;
      expectIssue(OP_SUB, 32'd9, 32'hAB, 32'd0, 32'h300, 4'd3, cyc + 2);
      tick(); idle();
      tick(); tick();

      // Both CDBs hit the same tag during dispatch: cdb0 value is kept.
      applyStimulus(OP_AND, 32'd1, 32'd0, 1'b0, 1'b1, 4'd0, 4'd2, 32'd0, 32'h304, 4'd4);
      bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'd2; bus.cdb0_value = 32'h1;
      bus.cdb1_valid = 1'b1; bus.cdb1_rob = 4'd2; bus.cdb1_value = 32'h2;
      expectIssue(OP_AND, 32'd1, 32'h1, 32'd0, 32'h304, 4'd4, cyc + 2);
      tick(); idle();
      tick(); tick();

      // Fill all eight entries, each waiting on tag 8+i.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(OP_OR, 32'd0, 32'(i), 1'b1, 1'b0, 4'(8 + i), 4'd0, 32'd0,
                       32'(4 * i), 4'(i));
         tick();
      end
      idle();
      checkOutput("fill_rs_full", {31'b0, bus.rs_full}, 32'd1);
      applyStimulus(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h500, 4'hF);
      tick(); idle();
      tick();
      checkOutput("full_still_full", {31'b0, bus.rs_full}, 32'd1);
      checkOutput("full_ninth_ignored", {31'b0, bus.RS_sgn}, 32'd0);

      // Wake entries 2 and 5 together; entry 2 goes first.
      bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'hA; bus.cdb0_value = 32'h22;
      bus.cdb1_valid = 1'b1; bus.cdb1_rob = 4'hD; bus.cdb1_value = 32'h55;
      expectIssue(OP_OR, 32'h22, 32'd2, 32'd0, 32'd8, 4'd2, cyc + 2);
      expectIssue(OP_OR, 32'h55, 32'd5, 32'd0, 32'd20, 4'd5, cyc + 3);
      tick(); idle();
      checkOutput("wake_cycle_still_full", {31'b0, bus.rs_full}, 32'd1);
      tick();
      checkOutput("after_issue_not_full", {31'b0, bus.rs_full}, 32'd0);
      tick(); tick();

      // Clear with a same-cycle dispatch: everything dropped.
      clear = 1'b1;
      applyStimulus(OP_ADD, 32'd3, 32'd3, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h600, 4'd9);
      tick(); clear = 1'b0; idle();
      checkOutput("clear_sgn", {31'b0, bus.RS_sgn}, 32'd0);
      bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'h8; bus.cdb0_value = 32'hDEAD;
      bus.cdb1_valid = 1'b1; bus.cdb1_rob = 4'hB; bus.cdb1_value = 32'hBEEF;
      tick(); idle();
      tick(); tick();
      checkOutput("clear_no_stale_issue", {31'b0, bus.RS_sgn}, 32'd0);

      // rdy low for three cycles during a broadcast and a dispatch.
      applyStimulus(OP_ADDI, 32'd0, 32'd0, 1'b1, 1'b0, 4'd6, 4'd0, 32'd3, 32'h300, 4'd6);
      tick(); idle();
      tick();
      rdy = 1'b0;
      bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'd6; bus.cdb0_value = 32'h77;
      applyStimulus(OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h700, 4'hE);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("rdy_low_sgn", {31'b0, bus.RS_sgn}, 32'd0);
         checkOutput("rdy_low_lhs_frozen", bus.lhs, 32'h55);
      end
      rdy = 1'b1; idle();
      tick(); tick();
      checkOutput("rdy_no_capture", {31'b0, bus.RS_sgn}, 32'd0);
      bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'd6; bus.cdb0_value = 32'h66;
      expectIssue(OP_ADDI, 32'h66, 32'd0, 32'd3, 32'h300, 4'd6, cyc + 2);
      tick(); idle();
      tick(); tick();

      // Reset mid-run with three busy entries.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_SUB, 32'd0, 32'd0, 1'b1, 1'b0, 4'd1, 4'd0, 32'd0, 32'h800, 4'(10 + i));
         tick();
      end
      idle();
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_sgn", {31'b0, bus.RS_sgn}, 32'd0);
      checkOutput("midreset_opcode", {26'b0, bus.RS_opcode}, 32'd0);
      checkOutput("midreset_lhs", bus.lhs, 32'd0);
      checkOutput("midreset_imm", bus.imm, 32'd0);
      checkOutput("midreset_pc", bus.pc, 32'd0);
      checkOutput("midreset_rob", {28'b0, bus.ROB_entry}, 32'd0);
      checkOutput("midreset_rs_full", {31'b0, bus.rs_full}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'd1; bus.cdb0_value = 32'h99;
      tick(); idle();
      tick(); tick();
      checkOutput("reset_no_stale_issue", {31'b0, bus.RS_sgn}, 32'd0);
      applyStimulus(OP_XOR, 32'h3, 32'h5, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'h400, 4'd7);
      expectIssue(OP_XOR, 32'h3, 32'h5, 32'd0, 32'h400, 4'd7, cyc + 2);
      tick(); idle();
      tick(); tick(); tick();

      checkOutput("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
